mac_rx_parser: RTL and testbench
================================

Name: mac_rx_parser

Overview:
Receive-side framing stage between the byte-wide PHY receive interface (rx_dv/rx_er/rxd) and the receive FIFO.
- Strips preamble and SFD.
- Forwards destination-address-through-FCS bytes into the FIFO write port.
- Counts frame length and flags runt, oversize, overflow and PHY-error frames with single-cycle status pulses.
- Errored frames stop writing immediately; bytes already written are left for the downstream frame logic to discard using frame_err.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS)
MAX_LEN, 1518, maximum legal frame length in bytes (DA through FCS)
LEN_W, 11, width of length counter and frame_len output

Ports:
clk  input  1  system clock; rxd sampled on rising edge
rst_n  input  1  asynchronous active-low reset
rx_dv  input  1  PHY receive data valid
rx_er  input  1  PHY receive error
rxd  input  8  PHY receive byte
fifo_full  input  1  full flag from receive FIFO
fifo_data  output  8  byte to FIFO data input
fifo_wr_en  output  1  FIFO write enable, one byte per cycle
frame_done  output  1  1-cycle pulse: good frame ended
frame_err  output  1  1-cycle pulse: frame ended/aborted with error
err_code  output  3  error cause, valid with frame_err, held until next pulse
frame_len  output  LEN_W  bytes counted in last frame, valid with either pulse, held

Behaviour:
- Interface timing: one clock, clk. Asynchronous active-low reset rst_n.
- Reset values: all outputs 0, state IDLE, byte counter 0.
- All outputs registered. Byte on rxd in cycle N with rx_dv=1 in DATA appears on fifo_data with fifo_wr_en=1 in cycle N+1.
- States:
  - IDLE:
    - rx_dv=1 & rxd=8'h55 -> PRE.
    - rx_dv=1 & other byte -> DROP.
  - PRE:
    - rx_dv=1 & rxd=8'h55 -> stay.
    - rxd=8'hD5 -> DATA, counter cleared.
    - rx_dv=1 & other byte -> DROP.
    - rx_dv=0 -> IDLE, no pulse.
  - DATA, each cycle with rx_dv=1:
    - write rxd and increment counter; counter saturates at 2^LEN_W-1.
    - rx_er=1 -> err_code=4, frame_err, no write, -> DROP.
    - fifo_full=1 -> err_code=3, frame_err, no write, -> DROP.
    - counter reaching MAX_LEN+1 -> err_code=2, frame_err, no write, -> DROP.
  - DATA, rx_dv falling (first cycle rx_dv=0):
    - len<MIN_LEN -> err_code=1 & frame_err; else frame_done (err_code unchanged).
    - -> IDLE.
  - DROP: no writes; stays until rx_dv=0, then -> IDLE. No further pulses.
- Error priority, same cycle: rx_er > fifo_full > oversize.
- frame_len updated in the same cycle as frame_done/frame_err, equal to bytes counted, including an aborted byte not written.
- err_code: 0 none, 1 runt, 2 oversize, 3 FIFO overflow, 4 PHY error, 5 CRC.
- rx_dv low for one cycle between frames suffices; back-to-back frames must not lose preamble detection.
- Reset asserted mid-frame: immediate return to IDLE, no pulse, fifo_wr_en low asynchronously.

Optional Feature:
MAC_RX_CRC_CHECK_EN
- Defined:
  - CRC-32 (poly 0x04C11DB7, init all-ones, reflected) runs over every DATA byte including FCS.
  - At rx_dv falling, register != residue 32'hC704DD7B and no runt -> err_code=5, frame_err instead of frame_done.
  - Runt takes priority over CRC.
  - CRC register reset to all-ones on SFD.
- Undefined: no CRC logic; code 5 never produced; timing unchanged.

Decomposition:
- Package mac_rx_pkg holds:
  - state enum (IDLE, PRE, DATA, DROP)
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5
  - err_code constants
  - CRC_POLY, CRC_RESIDUE
- Sub-module crc32_d8: combinational next-CRC from current CRC and 8-bit data. Instantiated only under MAC_RX_CRC_CHECK_EN.

Test Plan:
- 7x55, D5, 64 payload bytes 0x00..0x3F, rx_dv drop -> 64 writes in order, frame_done once, frame_len=64, no frame_err.
- Same preamble, 40 bytes -> 40 writes, frame_err, err_code=1, frame_len=40.
- 1519-byte frame -> 1518 writes, frame_err with err_code=2 at byte 1519, then silence until rx_dv low.
- 100-byte frame, fifo_full forced high at byte 10 -> 9 writes, err_code=3, frame_len=10, no more writes.
- rx_er pulse on byte 20 of a 100-byte frame -> 19 writes, err_code=4; preamble 55 55 AA -> DROP, zero writes, no pulse.
- CRC_EN, 64-byte frame with correct FCS -> frame_done; FCS last byte flipped -> frame_err, err_code=5. rst_n low at byte 30 -> outputs 0 immediately, next frame handled normally.

Source files
------------

// File: rtl/mac_rx_pkg.sv
// mac_rx_pkg: shared states, framing bytes, error codes and CRC-32 constants for mac_rx_parser.
package mac_rx_pkg;
    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_e;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_RUNT = 3'd1;
    localparam logic [2:0] ERR_OVERSIZE = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW = 3'd3;
    localparam logic [2:0] ERR_PHY = 3'd4;
    localparam logic [2:0] ERR_CRC = 3'd5;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: combinational CRC-32 update for one byte, data bits fed LSB first into an MSB-first register.
module crc32_d8
    import mac_rx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);
    always_comb begin
        crc_o = crc_i;
        for (int i = 0; i < 8; i++)
            crc_o = {crc_o[30:0], 1'b0} ^ ((crc_o[31] ^ data_i[i]) ? CRC_POLY : 32'h0);
    end
endmodule

// File: rtl/mac_rx_parser.sv
// mac_rx_parser: strips preamble/SFD, forwards DA..FCS bytes to the RX FIFO and flags frame status.
// Define MAC_RX_CRC_CHECK_EN to add FCS checking (err_code 5 on residue mismatch).
module mac_rx_parser
    import mac_rx_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_dv,
    input  logic             rx_er,
    input  logic [7:0]       rxd,
    input  logic             fifo_full,
    output logic [7:0]       fifo_data,
    output logic             fifo_wr_en,
    output logic             frame_done,
    output logic             frame_err,
    output logic [2:0]       err_code,
    output logic [LEN_W-1:0] frame_len
);
    state_e state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
    logic [7:0] data_q, data_d;
    logic wr_q, wr_d, done_q, done_d, err_q, err_d, abort, crc_bad;
    logic [2:0] code_q, code_d;

    // Counter saturates so an absurdly long frame can never wrap into a legal length.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign abort = rx_er || fifo_full || (cnt_inc > LEN_W'(MAX_LEN));

`ifdef MAC_RX_CRC_CHECK_EN
    logic [31:0] crc_q, crc_d, crc_nxt;
    crc32_d8 u_crc (.crc_i(crc_q), .data_i(rxd), .crc_o(crc_nxt));
    assign crc_d = (state_q == PRE && rxd == SFD_BYTE) ? CRC_INIT :
                   (state_q == DATA && rx_dv) ? crc_nxt : crc_q;
    assign crc_bad = crc_q != CRC_RESIDUE;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) crc_q <= CRC_INIT;
        else crc_q <= crc_d;
`else
    assign crc_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        len_d = len_q;
        data_d = data_q;
        code_d = code_q;
        wr_d = 1'b0;
        done_d = 1'b0;
        err_d = 1'b0;
        case (state_q)
            IDLE: if (rx_dv) state_d = (rxd == PREAMBLE_BYTE) ? PRE : DROP;
            PRE: begin
                if (!rx_dv) state_d = IDLE;
                else if (rxd == SFD_BYTE) begin
                    state_d = DATA;
                    cnt_d = '0;
                end else if (rxd != PREAMBLE_BYTE) state_d = DROP;
            end
            DATA: begin
                if (rx_dv) begin
                    cnt_d = cnt_inc;
                    if (abort) begin
                        state_d = DROP;
                        err_d = 1'b1;
                        len_d = cnt_inc;
                        code_d = rx_er ? ERR_PHY : fifo_full ? ERR_OVERFLOW : ERR_OVERSIZE;
                    end else begin
                        wr_d = 1'b1;
                        data_d = rxd;
                    end
                end else begin
                    state_d = IDLE;
                    len_d = cnt_q;
                    if (cnt_q < LEN_W'(MIN_LEN)) begin
                        err_d = 1'b1;
                        code_d = ERR_RUNT;
                    end else if (crc_bad) begin
                        err_d = 1'b1;
                        code_d = ERR_CRC;
                    end else done_d = 1'b1;
                end
            end
            default: if (!rx_dv) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            len_q <= '0;
            data_q <= '0;
            code_q <= ERR_NONE;
            wr_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
            data_q <= data_d;
            code_q <= code_d;
            wr_q <= wr_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    end

    assign fifo_data = data_q;
    assign fifo_wr_en = wr_q;
    assign frame_done = done_q;
    assign frame_err = err_q;
    assign err_code = code_q;
    assign frame_len = len_q;
endmodule

// File: tb/tb_mac_rx_parser.sv
// tb_mac_rx_parser: directed frames with hand-computed write counts, pulses, err_code and frame_len.
// Expectations for FCS checking follow MAC_RX_CRC_CHECK_EN.
module tb_mac_rx_parser;
`ifdef MAC_RX_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, rx_dv, rx_er, fifo_full;
    logic [7:0] rxd, fifo_data;
    logic fifo_wr_en, frame_done, frame_err;
    logic [2:0] err_code;
    logic [10:0] frame_len;

    mac_rx_parser dut (
        .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
        .fifo_full(fifo_full), .fifo_data(fifo_data), .fifo_wr_en(fifo_wr_en),
        .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
        .frame_len(frame_len)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0;
    int n_ferr = 0;
    logic [7:0] wr_q[$];
    logic [7:0] fb[0:1599];

    always @(negedge clk) begin
        if (fifo_wr_en) wr_q.push_back(fifo_data);
        if (frame_done) n_done <= n_done + 1;
        if (frame_err) n_ferr <= n_ferr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Standard reflected software CRC-32 with final inversion, giving the FCS to append.
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, fb[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic fill_seq(input int n);
        for (int i = 0; i < n; i++) fb[i] = 8'(i);
    endtask

    task automatic fill_crc(input int n);
        logic [31:0] c;
        for (int i = 0; i < n - 4; i++) fb[i] = 8'(i * 7 + 3);
        c = fcs_of(n - 4);
        fb[n-4] = c[7:0];
        fb[n-3] = c[15:8];
        fb[n-2] = c[23:16];
        fb[n-1] = c[31:24];
    endtask

    task automatic send(input int npre, input logic [7:0] sfd, input int len, input int full_at,
                        input int er_at, input int rst_at, input int gap);
        for (int p = 0; p < npre; p++) begin
            @(negedge clk);
            rx_dv = 1'b1;
            rxd = 8'h55;
        end
        @(negedge clk);
        rxd = sfd;
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            if (i == rst_at) begin
                #2;
                check("pre_rst_wr", fifo_wr_en, 1);
                rst_n = 1'b0;
                rx_dv = 1'b0;
                #1;
                check("rst_wr", fifo_wr_en, 0);
                check("rst_len", frame_len, 0);
                check("rst_code", err_code, 0);
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            rxd = fb[i-1];
            fifo_full = (full_at != 0) && (i >= full_at);
            rx_er = (i == er_at);
        end
        @(negedge clk);
        rx_dv = 1'b0;
        rx_er = 1'b0;
        fifo_full = 1'b0;
        rxd = 8'h00;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic frame(input string t, input int npre, input logic [7:0] sfd, input int len,
                         input int full_at, input int er_at, input int rst_at, input int nfr,
                         input int writes, input int done, input int errs,
                         input int code, input int flen);
        int w0, d0, e0, bad;
        w0 = wr_q.size();
        d0 = n_done;
        e0 = n_ferr;
        for (int f = 0; f < nfr; f++) send(npre, sfd, len, full_at, er_at, rst_at, (f == nfr - 1) ? 4 : 1);
        bad = 0;
        for (int k = 0; k < writes && w0 + k < wr_q.size(); k++)
            if (wr_q[w0+k] !== fb[k % len]) bad++;
        check({t, "_writes"}, wr_q.size() - w0, writes);
        check({t, "_data"}, bad, 0);
        check({t, "_done"}, n_done - d0, done);
        check({t, "_err"}, n_ferr - e0, errs);
        check({t, "_code"}, err_code, code);
        check({t, "_len"}, frame_len, flen);
    endtask

    initial begin
        rst_n = 1'b0;
        rx_dv = 1'b0;
        rx_er = 1'b0;
        fifo_full = 1'b0;
        rxd = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_wr", fifo_wr_en, 0);
        check("reset_data", fifo_data, 0);
        check("reset_done", frame_done, 0);
        check("reset_err", frame_err, 0);
        check("reset_code", err_code, 0);
        check("reset_len", frame_len, 0);
        rst_n = 1'b1;
        @(negedge clk);

        fill_seq(64);
        frame("good64", 7, 8'hD5, 64, 0, 0, 0, 1, 64, CRC_EN ? 0 : 1, CRC_EN ? 1 : 0, CRC_EN ? 5 : 0, 64);
        frame("runt40", 7, 8'hD5, 40, 0, 0, 0, 1, 40, 0, 1, 1, 40);
        frame("runt63", 7, 8'hD5, 63, 0, 0, 0, 1, 63, 0, 1, 1, 63);
        fill_crc(64);
        frame("crc64", 7, 8'hD5, 64, 0, 0, 0, 1, 64, 1, 0, 1, 64);
        fill_seq(1600);
        frame("oversize", 7, 8'hD5, 1522, 0, 0, 0, 1, 1518, 0, 1, 2, 1519);
        frame("fifo_full", 7, 8'hD5, 100, 10, 0, 0, 1, 9, 0, 1, 3, 10);
        frame("rx_er", 7, 8'hD5, 100, 0, 20, 0, 1, 19, 0, 1, 4, 20);
        frame("bad_pre", 2, 8'hAA, 50, 0, 0, 0, 1, 0, 0, 0, 4, 20);
        fill_crc(64);
        frame("b2b", 7, 8'hD5, 64, 0, 0, 0, 2, 128, 2, 0, 4, 64);
        fb[63] = ~fb[63];
        frame("crc_flip", 7, 8'hD5, 64, 0, 0, 0, 1, 64, CRC_EN ? 0 : 1, CRC_EN ? 1 : 0, CRC_EN ? 5 : 4, 64);
        frame("reset_mid", 7, 8'hD5, 64, 0, 0, 30, 1, 29, 0, 0, 0, 0);
        fill_crc(64);
        frame("after_rst", 7, 8'hD5, 64, 0, 0, 0, 1, 64, 1, 0, 0, 64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
